// File: rtl/weight_control_unit_pkg.sv
// Shared types for the weight control unit: byte lanes, FSM encoding and read-pipe entries.
package weight_control_unit_pkg;

  typedef logic [7:0] byte_type;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    READY,
    ACTIVATE
  } weight_ctrl_state_t;

  typedef struct packed {
    logic     valid;
    logic     zero;
    byte_type idx;
  } weight_pipe_entry_t;

endpackage

// File: rtl/weight_control_unit_if.sv
// Instruction, weight-buffer and MMU signals of the weight control unit.
// slave = controller view, master = decoder/buffer/MMU view.
interface weight_control_unit_if #(
  parameter int MATRIX_WIDTH      = 14,
  parameter int BUFFER_ADDR_WIDTH = 16
);
  import weight_control_unit_pkg::*;

  localparam int ROWS_WIDTH = $clog2(MATRIX_WIDTH + 1);

  logic                              stall;
  logic                              instr_valid;
  logic                              instr_ready;
  logic [BUFFER_ADDR_WIDTH-1:0]      instr_base_addr;
  logic [ROWS_WIDTH-1:0]             instr_rows;
  logic                              instr_signed;
  logic                              buf_en;
  logic [BUFFER_ADDR_WIDTH-1:0]      buf_addr;
  byte_type [MATRIX_WIDTH-1:0]       buf_data;
  byte_type [MATRIX_WIDTH-1:0]       weight_data;
  logic                              weight_signed;
  logic                              load_weight;
  byte_type                          weight_addr;
  logic                              activate_req;
  logic                              activate_weight;
  logic                              weights_ready;
  logic                              busy;

  modport slave (
    input  stall, instr_valid, instr_base_addr, instr_rows, instr_signed, buf_data, activate_req,
    output instr_ready, buf_en, buf_addr, weight_data, weight_signed, load_weight, weight_addr,
           activate_weight, weights_ready, busy
  );

  modport master (
    output stall, instr_valid, instr_base_addr, instr_rows, instr_signed, buf_data, activate_req,
    input  instr_ready, buf_en, buf_addr, weight_data, weight_signed, load_weight, weight_addr,
           activate_weight, weights_ready, busy
  );

endinterface

// File: rtl/weight_control_unit_read_pipe.sv
// Fixed-latency delay line tracking rows in flight through the weight buffer.
module weight_read_pipe
  import weight_control_unit_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  weight_pipe_entry_t in_entry,
  output weight_pipe_entry_t tail,
  output logic               busy
);

  weight_pipe_entry_t stage_q [READ_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_entry;
      for (int i = 1; i < READ_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) busy = busy | stage_q[i].valid;
  end

  assign tail = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/weight_control_unit.sv
// Weight-side controller: fetches a tile from the weight buffer, preloads it into the MMU and
// fires activation on request. Build option WEIGHT_ZERO_FILL_EN pads every tile to MATRIX_WIDTH rows.
//
//   state    | meaning
//   IDLE     | waiting for a tile instruction (instr_ready=1)
//   LOAD     | issuing row reads / zero rows, one per non-stalled cycle
//   DRAIN    | all rows issued, waiting for the read pipe to empty
//   READY    | full tile preloaded, waiting for activate_req
//   ACTIVATE | one-cycle activate_weight pulse
module weight_control_unit
  import weight_control_unit_pkg::*;
#(
  parameter int MATRIX_WIDTH      = 14,
  parameter int BUFFER_ADDR_WIDTH = 16,
  parameter int READ_LATENCY      = 2
) (
  input logic                 clk,
  input logic                 rst,
  weight_control_unit_if.slave bus
);

  localparam int RW = $clog2(MATRIX_WIDTH + 1);
  localparam logic [RW-1:0] FULL_ROWS = RW'(MATRIX_WIDTH);

  weight_ctrl_state_t            state_q, state_d;
  logic                          ready_q;
  logic [BUFFER_ADDR_WIDTH-1:0]  base_q;
  logic [RW-1:0]                 rows_q, k_q, issue_len, rows_dec;
  logic                          signed_q;
  logic                          load_q;
  byte_type                      waddr_q;
  byte_type [MATRIX_WIDTH-1:0]   wdata_q;

  logic                          accept, issue, last_issue, pipe_busy;
  logic                          buf_en_c;
  logic [BUFFER_ADDR_WIDTH-1:0]  buf_addr_c;
  weight_pipe_entry_t            pipe_in, pipe_tail;

`ifdef WEIGHT_ZERO_FILL_EN
  assign issue_len = FULL_ROWS;
`else
  assign issue_len = rows_q;
`endif

  assign rows_dec   = (bus.instr_rows == '0 || bus.instr_rows > FULL_ROWS) ? FULL_ROWS : bus.instr_rows;
  assign accept     = bus.instr_valid && ready_q;
  assign issue      = (state_q == LOAD) && !bus.stall;
  assign last_issue = issue && (k_q == issue_len - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = LOAD;
      LOAD:     if (last_issue) state_d = DRAIN;
      DRAIN:    if (!pipe_busy) state_d = READY;
      READY:    if (bus.activate_req && !bus.stall) state_d = ACTIVATE;
      ACTIVATE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_en_c      = issue && (k_q < rows_q);
    buf_addr_c    = buf_en_c ? base_q + BUFFER_ADDR_WIDTH'(k_q) : '0;
    pipe_in       = '0;
    pipe_in.valid = issue;
    pipe_in.zero  = issue && !(k_q < rows_q);
    pipe_in.idx   = issue ? 8'(k_q) : '0;
  end

  // ready_q mirrors state==IDLE but stays low while reset is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      base_q   <= '0;
      rows_q   <= '0;
      signed_q <= 1'b0;
      k_q      <= '0;
      load_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      if (accept) begin
        base_q   <= bus.instr_base_addr;
        rows_q   <= rows_dec;
        signed_q <= bus.instr_signed;
        k_q      <= '0;
      end else if (issue) begin
        k_q <= k_q + 1'b1;
      end
      load_q  <= pipe_tail.valid;
      waddr_q <= pipe_tail.valid ? pipe_tail.idx : '0;
      wdata_q <= (pipe_tail.valid && !pipe_tail.zero) ? bus.buf_data : '0;
    end
  end

  weight_read_pipe #(.READ_LATENCY(READ_LATENCY)) u_read_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_entry (pipe_in),
    .tail     (pipe_tail),
    .busy     (pipe_busy)
  );

  assign bus.instr_ready     = ready_q;
  assign bus.buf_en          = buf_en_c;
  assign bus.buf_addr        = buf_addr_c;
  assign bus.weight_data     = wdata_q;
  assign bus.weight_signed   = signed_q;
  assign bus.load_weight     = load_q;
  assign bus.weight_addr     = waddr_q;
  assign bus.activate_weight = (state_q == ACTIVATE);
  assign bus.weights_ready   = (state_q == READY);
  assign bus.busy            = (state_q != IDLE) || pipe_busy;

endmodule

// File: tb/tb_weight_control_unit.sv
// Self-checking bench for weight_control_unit (MATRIX_WIDTH=4, READ_LATENCY=2).
module tb_weight_control_unit;
  import weight_control_unit_pkg::*;

  localparam int MW = 4;
  localparam int RL = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   checks, passes, fails;

  weight_control_unit_if #(.MATRIX_WIDTH(MW), .BUFFER_ADDR_WIDTH(16)) bus ();

  weight_control_unit #(.MATRIX_WIDTH(MW), .BUFFER_ADDR_WIDTH(16), .READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // weight buffer: deterministic content per address, fixed read latency, junk when not reading
  logic [31:0] seed;
  logic [15:0] ap [RL];
  logic        av [RL];
  logic [31:0] junk;

  function automatic logic [31:0] row_of(input logic [15:0] a);
    logic [31:0] r;
    for (int j = 0; j < MW; j++) r[j*8 +: 8] = a[7:0] ^ a[15:8] ^ seed[j*8 +: 8] ^ 8'(j * 29 + 1);
    return r;
  endfunction

  always @(posedge clk) begin
    av[0] <= bus.buf_en;
    ap[0] <= bus.buf_addr;
    for (int i = 1; i < RL; i++) begin
      av[i] <= av[i-1];
      ap[i] <= ap[i-1];
    end
    junk <= $urandom;
  end

  always_comb bus.buf_data = av[RL-1] ? row_of(ap[RL-1]) : junk;

  // monitor
  int          rd_cyc[$], ld_cyc[$], act_cyc[$], acc_cyc[$];
  logic [15:0] rd_addr[$];
  byte_type    ld_addr[$];
  logic [31:0] ld_data[$];
  int          wr_rise;
  logic        wr_prev;
  int          idle_bad;
  bit          stall_hist [0:8191];

  initial begin
    idle_bad = 0;
    wr_prev  = 1'b0;
    wr_rise  = -1;
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_hist[cyc] = bus.stall;
      if (bus.buf_en) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(bus.buf_addr);
      end
      if (bus.load_weight) begin
        ld_cyc.push_back(cyc);
        ld_addr.push_back(bus.weight_addr);
        ld_data.push_back(bus.weight_data);
      end else if (bus.weight_data != '0 || bus.weight_addr != '0) begin
        idle_bad = idle_bad + 1;
      end
      if (bus.activate_weight) act_cyc.push_back(cyc);
      if (bus.instr_valid && bus.instr_ready) acc_cyc.push_back(cyc);
      if (bus.weights_ready && !wr_prev) wr_rise = cyc;
      wr_prev = bus.weights_ready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    rd_cyc.delete(); rd_addr.delete();
    ld_cyc.delete(); ld_addr.delete(); ld_data.delete();
    act_cyc.delete(); acc_cyc.delete();
    wr_rise = -1;
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_instr_ready"}, 64'(bus.instr_ready), 64'(0));
    check({p, "_buf_en"}, 64'(bus.buf_en), 64'(0));
    check({p, "_buf_addr"}, 64'(bus.buf_addr), 64'(0));
    check({p, "_weight_data"}, 64'(bus.weight_data), 64'(0));
    check({p, "_weight_signed"}, 64'(bus.weight_signed), 64'(0));
    check({p, "_load_weight"}, 64'(bus.load_weight), 64'(0));
    check({p, "_weight_addr"}, 64'(bus.weight_addr), 64'(0));
    check({p, "_activate"}, 64'(bus.activate_weight), 64'(0));
    check({p, "_weights_ready"}, 64'(bus.weights_ready), 64'(0));
    check({p, "_busy"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic send(input logic [15:0] base, input int n, input logic sgn, output int t);
    int w = 0;
    while (!bus.instr_ready && w < 50) begin
      step(1);
      w++;
    end
    check("instr_ready_seen", 64'(bus.instr_ready), 64'(1));
    clear_mon();
    bus.instr_valid     = 1'b1;
    bus.instr_base_addr = base;
    bus.instr_rows      = 3'(n);
    bus.instr_signed    = sgn;
    t = cyc;
    step(1);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_ready(input bit rnd_stall);
    int w = 0;
    while (!bus.weights_ready && w < 200) begin
      if (rnd_stall) bus.stall = ($urandom_range(0, 3) == 0);
      step(1);
      w++;
    end
    bus.stall = 1'b0;
    check("ready_seen", 64'(bus.weights_ready), 64'(1));
    @(negedge clk);
    #1;
  endtask

  // reference: the first L non-stalled cycles after accept issue rows 0..L-1 in order;
  // each row lands RL+1 cycles after issue, ready follows the last landing
  task automatic check_tile(input int t, input logic [15:0] base, input int n, input logic sgn);
    int ne, len, c;
    int ic[$];
    ne = (n == 0 || n > MW) ? MW : n;
`ifdef WEIGHT_ZERO_FILL_EN
    len = MW;
`else
    len = ne;
`endif
    c = t + 1;
    for (int k = 0; k < len; k++) begin
      while (stall_hist[c]) c++;
      ic.push_back(c);
      c++;
    end
    check("rd_count", 64'(rd_addr.size()), 64'(ne));
    for (int k = 0; k < ne; k++) begin
      if (k < rd_addr.size()) begin
        check("rd_addr", 64'(rd_addr[k]), 64'(16'(base + 16'(k))));
        check("rd_cycle", 64'(rd_cyc[k]), 64'(ic[k]));
      end
    end
    check("ld_count", 64'(ld_addr.size()), 64'(len));
    for (int k = 0; k < len; k++) begin
      if (k < ld_addr.size()) begin
        check("ld_addr", 64'(ld_addr[k]), 64'(k));
        check("ld_data", 64'(ld_data[k]), 64'((k < ne) ? row_of(16'(base + 16'(k))) : 32'h0));
        check("ld_cycle", 64'(ld_cyc[k]), 64'(ic[k] + RL + 1));
      end
    end
    check("ready_cycle", 64'(wr_rise), 64'(ic[len-1] + RL + 2));
    check("weight_signed", 64'(bus.weight_signed), 64'(sgn));
  endtask

  task automatic do_activate();
    int c;
    act_cyc.delete();
    bus.activate_req = 1'b1;
    c = cyc;
    step(1);
    bus.activate_req = 1'b0;
    step(2);
    check("act_count", 64'(act_cyc.size()), 64'(1));
    if (act_cyc.size() > 0) check("act_cycle", 64'(act_cyc[0]), 64'(c + 1));
    check("ready_after_act", 64'(bus.weights_ready), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t, c;
    logic [15:0] b;
    int          n;
    logic        s;
    checks = 0; passes = 0; fails = 0;
    seed = $urandom;
    rst = 1'b0;
    bus.stall = 1'b0; bus.instr_valid = 1'b0; bus.instr_base_addr = '0;
    bus.instr_rows = '0; bus.instr_signed = 1'b0; bus.activate_req = 1'b0;

    step(3);
    @(negedge clk);
    check_all_zero("reset");
    step(1);
    rst = 1'b1;
    step(2);

    // reset in the middle of LOAD
    send(16'h0040, 4, 1'b1, t);
    step(2);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    step(2);
    rst = 1'b1;
    clear_mon();
    step(8);
    check("post_reset_ready", 64'(bus.instr_ready), 64'(1));
    check("post_reset_loads", 64'(ld_addr.size()), 64'(0));
    check("post_reset_reads", 64'(rd_addr.size()), 64'(0));
    check("post_reset_busy", 64'(bus.busy), 64'(0));

    // full tile
    send(16'h0010, 4, 1'b0, t);
    check("busy_in_load", 64'(bus.busy), 64'(1));
    wait_ready(1'b0);
    check_tile(t, 16'h0010, 4, 1'b0);
    do_activate();

    // short tile
    send(16'h1234, 2, 1'b1, t);
    wait_ready(1'b0);
    check_tile(t, 16'h1234, 2, 1'b1);
    do_activate();

    // address wrap
    send(16'hFFFF, 3, 1'b0, t);
    wait_ready(1'b0);
    check_tile(t, 16'hFFFF, 3, 1'b0);
    do_activate();

    // stall T+2..T+4, then activate held off by stall
    b = 16'($urandom);
    send(b, 4, 1'b0, t);
    step(1);
    bus.stall = 1'b1;
    step(3);
    bus.stall = 1'b0;
    wait_ready(1'b0);
    check_tile(t, b, 4, 1'b0);
    if (rd_cyc.size() > 1) check("stall_resume", 64'(rd_cyc[1]), 64'(t + 5));
    act_cyc.delete();
    bus.stall = 1'b1;
    bus.activate_req = 1'b1;
    c = cyc;
    step(3);
    bus.stall = 1'b0;
    step(1);
    bus.activate_req = 1'b0;
    step(2);
    check("stall_act_count", 64'(act_cyc.size()), 64'(1));
    if (act_cyc.size() > 0) check("stall_act_cycle", 64'(act_cyc[0]), 64'(c + 4));

    // activate and instruction together while READY
    send(16'h0200, 0, 1'b1, t);
    wait_ready(1'b0);
    check_tile(t, 16'h0200, 0, 1'b1);
    clear_mon();
    c = cyc;
    bus.activate_req = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_base_addr = 16'h0300; bus.instr_rows = 3'd3; bus.instr_signed = 1'b0;
    step(1);
    bus.activate_req = 1'b0;
    step(2);
    bus.instr_valid = 1'b0;
    check("race_act_count", 64'(act_cyc.size()), 64'(1));
    if (act_cyc.size() > 0) check("race_act_cycle", 64'(act_cyc[0]), 64'(c + 1));
    check("race_acc_count", 64'(acc_cyc.size()), 64'(1));
    if (acc_cyc.size() > 0) check("race_acc_cycle", 64'(acc_cyc[0]), 64'(c + 2));
    wait_ready(1'b0);
    check_tile(c + 2, 16'h0300, 3, 1'b0);
    do_activate();
    act_cyc.delete();
    bus.activate_req = 1'b1;
    step(2);
    bus.activate_req = 1'b0;
    step(2);
    check("idle_act_ignored", 64'(act_cyc.size()), 64'(0));

    // random tiles with random stalls
    for (int i = 0; i < 10; i++) begin
      b = 16'($urandom);
      n = $urandom_range(0, 7);
      s = 1'($urandom);
      send(b, n, s, t);
      wait_ready(1'b1);
      check_tile(t, b, n, s);
      do_activate();
    end

    check("idle_outputs_zero", 64'(idle_bad), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
